// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Default entry layout, control-flow opcode decode and hold-state encoding.
package if_prefetch_queue_pkg;

  localparam int PF_XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [PF_XLEN-1:0] PC;
    logic [PF_XLEN-1:0] NPC;
    logic [PF_XLEN-1:0] IR;
  } fetch_entry_t;

  typedef enum logic {
    HOLD_OPEN = 1'b0,
    HOLD_WAIT = 1'b1
  } hold_state_t;

  function automatic logic is_ctrl_op(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch-side, head-side and status signals of the prefetch queue.
// master drives fetch/consume/flush controls; slave is the queue itself.
interface if_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            fetch_valid;
  logic [XLEN-1:0] fetch_PC;
  logic [XLEN-1:0] fetch_NPC;
  logic [XLEN-1:0] fetch_IR;
  logic            fetch_ready;
  logic            deq_ready;
  logic            q_valid;
  logic [XLEN-1:0] q_PC;
  logic [XLEN-1:0] q_NPC;
  logic [XLEN-1:0] q_IR;
  logic            q_is_ctrl;
  logic            flush;
  logic            ctrl_resolved;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            ctrl_hold;

  modport master (
    output fetch_valid, fetch_PC, fetch_NPC, fetch_IR, deq_ready, flush, ctrl_resolved,
    input  fetch_ready, q_valid, q_PC, q_NPC, q_IR, q_is_ctrl, count, full, empty, ctrl_hold
  );

  modport slave (
    input  fetch_valid, fetch_PC, fetch_NPC, fetch_IR, deq_ready, flush, ctrl_resolved,
    output fetch_ready, q_valid, q_PC, q_NPC, q_IR, q_is_ctrl, count, full, empty, ctrl_hold
  );

endinterface

// File: rtl/if_prefetch_queue_pf_ring_buf.sv
// Generic DEPTH-entry circular buffer with occupancy, full/empty and a synchronous clear.
// Writes are visible at the read port one edge later; writes when full and reads when empty are dropped.
module pf_ring_buf
  import if_prefetch_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  T                             wr_dat,
  input  logic                         rd_en,
  output T                             rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ok  = wr_en && !full && !clr;
  assign rd_ok  = rd_en && !empty && !clr;
  assign rd_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Prefetch queue between IF and IF/ID: ring buffer plus handshake, flush priority and control-flow hold.
// Head is valid one edge after enqueue; fetch_ready depends only on state and flush, never on deq_ready.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH        = 4,
  parameter int              XLEN         = 32,
  parameter int              STOP_AT_CTRL = 1,
  parameter logic [XLEN-1:0] NOOP_IR      = 32'h00000013
) (
  input logic               clk,
  input logic               rst,
  if_prefetch_queue_if.slave pq
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] IR;
  } entry_t;

  entry_t        wr_dat;
  entry_t        head;
  logic          enq;
  logic          deq;
  logic          full;
  logic          empty;
  logic          fetch_ready;
  logic          ctrl_hold;
  logic [CW-1:0] count;

  assign fetch_ready = !full && !ctrl_hold && !pq.flush;
  assign enq         = pq.fetch_valid && fetch_ready;
  assign deq         = pq.deq_ready && !empty && !pq.flush;
  assign wr_dat      = '{PC: pq.fetch_PC, NPC: pq.fetch_NPC, IR: pq.fetch_IR};

  pf_ring_buf #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clr    (pq.flush),
    .wr_en  (enq),
    .wr_dat (wr_dat),
    .rd_en  (deq),
    .rd_dat (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Only one control instruction may be in flight, so set and resolve never coincide.
  generate
    if (STOP_AT_CTRL != 0) begin : g_hold
      hold_state_t hold_q;
      hold_state_t hold_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= HOLD_OPEN;
        else     hold_q <= hold_d;
      end

      always_comb begin
        hold_d = hold_q;
        case (hold_q)
          HOLD_OPEN: if (enq && is_ctrl_op(pq.fetch_IR[6:0])) hold_d = HOLD_WAIT;
          HOLD_WAIT: if (pq.flush || pq.ctrl_resolved)        hold_d = HOLD_OPEN;
          default:   hold_d = HOLD_OPEN;
        endcase
      end

      assign ctrl_hold = (hold_q == HOLD_WAIT);
    end else begin : g_no_hold
      assign ctrl_hold = 1'b0;
    end
  endgenerate

  assign pq.fetch_ready = fetch_ready;
  assign pq.count       = count;
  assign pq.full        = full;
  assign pq.empty       = empty;
  assign pq.ctrl_hold   = ctrl_hold;
  assign pq.q_valid     = !empty;
  assign pq.q_PC        = empty ? '0 : head.PC;
  assign pq.q_NPC       = empty ? '0 : head.NPC;
  assign pq.q_IR        = empty ? NOOP_IR : head.IR;
  assign pq.q_is_ctrl   = !empty && is_ctrl_op(head.IR[6:0]);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: directed scenarios then random traffic against a queue model.
module tb_if_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOOP  = 32'h00000013;
  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] BEQ   = 32'h00000463;
  localparam logic [31:0] JAL   = 32'h0080006F;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) a ();
  if_prefetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) b ();

  if_prefetch_queue #(.DEPTH(DEPTH), .XLEN(32), .STOP_AT_CTRL(1), .NOOP_IR(NOOP))
    u_dut (.clk(clk), .rst(rst), .pq(a));
  if_prefetch_queue #(.DEPTH(DEPTH), .XLEN(32), .STOP_AT_CTRL(0), .NOOP_IR(NOOP))
    u_dut_nostop (.clk(clk), .rst(rst), .pq(b));

  ent_t        exp_q[$];
  bit          mhold;
  logic [31:0] pc_next;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ctrl_of(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       op = 7'h6F;
      1:       op = 7'h67;
      2:       op = 7'h63;
      default: op = 7'h13;
    endcase
    return {r[31:7], op};
  endfunction

  // Head checker: compares whatever the queue presents against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (a.q_valid) begin
        if (exp_q.size() == 0) chk("head_valid_when_model_empty", a.q_valid, 1'b0);
        else begin
          chk("head_pc",   a.q_PC,      exp_q[0].pc);
          chk("head_npc",  a.q_NPC,     exp_q[0].npc);
          chk("head_ir",   a.q_IR,      exp_q[0].ir);
          chk("head_ctrl", a.q_is_ctrl, ctrl_of(exp_q[0].ir));
          if (a.deq_ready && !a.flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_pc",   a.q_PC,      32'h0);
        chk("idle_npc",  a.q_NPC,     32'h0);
        chk("idle_ir",   a.q_IR,      NOOP);
        chk("idle_ctrl", a.q_is_ctrl, 1'b0);
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input bit fv, input logic [31:0] ir, input bit dr, input bit fl, input bit cr);
    bit rdy;
    bit enq;
    chk("count",     32'(a.count), exp_q.size());
    chk("empty",     a.empty,      exp_q.size() == 0);
    chk("full",      a.full,       exp_q.size() == DEPTH);
    chk("q_valid",   a.q_valid,    exp_q.size() != 0);
    chk("ctrl_hold", a.ctrl_hold,  mhold);
    a.fetch_valid   = fv;
    a.fetch_PC      = pc_next;
    a.fetch_NPC     = pc_next + 32'd4;
    a.fetch_IR      = ir;
    a.deq_ready     = dr;
    a.flush         = fl;
    a.ctrl_resolved = cr;
    #1;
    rdy = (exp_q.size() < DEPTH) && !mhold && !fl;
    chk("fetch_ready", a.fetch_ready, rdy);
    enq = fv && rdy;
    @(negedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      mhold   = 1'b0;
      pc_next = $urandom_range(0, 1023) * 4;
    end else begin
      if (enq) begin
        exp_q.push_back('{pc_next, pc_next + 32'd4, ir});
        pc_next = pc_next + 32'd4;
      end
      if (cr) mhold = 1'b0;
      else if (enq && ctrl_of(ir)) mhold = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a.fetch_valid = 0; a.deq_ready = 0; a.flush = 0; a.ctrl_resolved = 0;
    a.fetch_PC = '0; a.fetch_NPC = '0; a.fetch_IR = NOOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit fv;
    bit dr;
    bit fl;
    bit cr;
    idle_a();
    b.fetch_valid = 0; b.deq_ready = 0; b.flush = 0; b.ctrl_resolved = 0;
    b.fetch_PC = '0; b.fetch_NPC = '0; b.fetch_IR = NOOP;
    mhold   = 1'b0;
    pc_next = 32'h0;
    #2;
    chk("rst_valid", a.q_valid,     1'b0);
    chk("rst_ready", a.fetch_ready, 1'b1);
    chk("rst_ir",    a.q_IR,        NOOP);
    chk("rst_empty", a.empty,       1'b1);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full without consuming, then one deq with a blocked fetch.
    repeat (4) cyc(1, ADDI, 0, 0, 0);
    cyc(0, ADDI, 0, 0, 0);
    cyc(1, ADDI, 1, 0, 0);
    // Flush with three entries and a concurrent fetch and deq.
    cyc(1, ADDI, 1, 1, 0);
    cyc(0, ADDI, 0, 0, 0);
    // Continuous stream through pointer wrap.
    repeat (12) cyc(1, ADDI, 1, 0, 0);
    repeat (2) cyc(0, ADDI, 1, 0, 0);

    // Control hold released by resolution, then by flush.
    cyc(1, BEQ,  0, 0, 0);
    cyc(1, ADDI, 0, 0, 0);
    cyc(1, ADDI, 0, 0, 1);
    cyc(1, ADDI, 0, 0, 0);
    cyc(1, BEQ,  0, 0, 0);
    cyc(1, ADDI, 0, 0, 0);
    cyc(1, ADDI, 0, 1, 0);
    cyc(1, ADDI, 0, 0, 0);
    cyc(1, BEQ,  0, 0, 0);

    // Asynchronous reset between edges with two entries and hold set.
    idle_a();
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", a.q_valid,     1'b0);
    chk("arst_count", 32'(a.count),  32'd0);
    chk("arst_hold",  a.ctrl_hold,   1'b0);
    chk("arst_ready", a.fetch_ready, 1'b1);
    chk("arst_ir",    a.q_IR,        NOOP);
    chk("arst_pc",    a.q_PC,        32'h0);
    exp_q.delete();
    mhold   = 1'b0;
    pc_next = 32'h100;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, ADDI, 0, 0, 0);
    cyc(0, ADDI, 1, 0, 0);

    // Random traffic.
    repeat (800) begin
      fv = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 19) == 0);
      if (mhold) cr = ($urandom_range(0, 4) == 0);
      else       cr = !fv && ($urandom_range(0, 19) == 0);
      cyc(fv, rand_ir(), dr, fl, cr);
    end
    repeat (DEPTH + 1) cyc(0, ADDI, 1, 0, 0);
    chk("drain_empty", a.empty, 1'b1);
    idle_a();

    // Instance without control stop: JAL then ADDI back to back.
    b.fetch_valid = 1; b.fetch_PC = 32'h0; b.fetch_NPC = 32'h4; b.fetch_IR = JAL;
    #1;
    chk("ns_ready0", b.fetch_ready, 1'b1);
    @(posedge clk);
    #1;
    b.fetch_PC = 32'h4; b.fetch_NPC = 32'h8; b.fetch_IR = ADDI;
    #1;
    chk("ns_hold1",  b.ctrl_hold,   1'b0);
    chk("ns_ready1", b.fetch_ready, 1'b1);
    chk("ns_ctrl1",  b.q_is_ctrl,   1'b1);
    chk("ns_ir1",    b.q_IR,        JAL);
    @(posedge clk);
    #1;
    b.fetch_valid = 0;
    chk("ns_count2", 32'(b.count), 32'd2);
    chk("ns_hold2",  b.ctrl_hold,  1'b0);
    chk("ns_ctrl2",  b.q_is_ctrl,  1'b1);
    b.deq_ready = 1;
    @(posedge clk);
    #1;
    b.deq_ready = 0;
    chk("ns_ir3",    b.q_IR,       ADDI);
    chk("ns_pc3",    b.q_PC,       32'h4);
    chk("ns_ctrl3",  b.q_is_ctrl,  1'b0);
    chk("ns_count3", 32'(b.count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
